// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response and ALU signal bundle for alu_arbiter
interface alu_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 2
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_c;
   logic             rsp0_zero;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_c;
   logic             rsp1_zero;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_c;
   logic             alu_zero;

   logic             busy;

   // arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
      output req0_ready, rsp0_valid, rsp0_c, rsp0_zero,
      input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
      output req1_ready, rsp1_valid, rsp1_c, rsp1_zero,
      output alu_a, alu_b, alu_op,
      input  alu_c, alu_zero,
      output busy
   );

   // requester / ALU side
   modport master (
      output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
      input  req0_ready, rsp0_valid, rsp0_c, rsp0_zero,
      output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
      input  req1_ready, rsp1_valid, rsp1_c, rsp1_zero,
      input  alu_a, alu_b, alu_op,
      output alu_c, alu_zero,
      input  busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one single-cycle ALU between two requesters
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             last;
   logic             owner;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [OPW-1:0]   op_code;
   logic [WIDTH-1:0] res_c;
   logic             res_zero;

   logic             gnt0;
   logic             gnt1;
   logic             ready0;
   logic             ready1;
   logic             accept;
   logic             rsp_hs;
   logic             rsp0_valid;
   logic             rsp1_valid;
   logic             busy;

   // Round-robin pick: a lone valid wins, a tie goes to whoever was not served last.
   always_comb begin
      gnt0 = bus.req0_valid & (~bus.req1_valid | last);
      gnt1 = bus.req1_valid & (~bus.req0_valid | ~last);
   end

   // Sequencer next state and handshake outputs; readies only ever rise in IDLE.
   always_comb begin
      state_nxt  = state;
      ready0     = 1'b0;
      ready1     = 1'b0;
      accept     = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp_hs     = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy   = 1'b0;
            ready0 = gnt0;
            ready1 = gnt1;
            accept = gnt0 | gnt1;
            if (accept) state_nxt = EXEC;
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp0_valid = ~owner;
            rsp1_valid = owner;
            rsp_hs     = owner ? bus.rsp1_ready : bus.rsp0_ready;
            if (rsp_hs) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand capture on acceptance, result capture in EXEC, fairness pointer on response handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= '0;
         op_b     <= '0;
         op_code  <= '0;
         owner    <= 1'b0;
         res_c    <= '0;
         res_zero <= 1'b0;
         last     <= 1'b1;
      end else begin
         if (accept) begin
            op_a    <= gnt1 ? bus.req1_a  : bus.req0_a;
            op_b    <= gnt1 ? bus.req1_b  : bus.req0_b;
            op_code <= gnt1 ? bus.req1_op : bus.req0_op;
            owner   <= gnt1;
         end
         if (state == EXEC) begin
            res_c    <= bus.alu_c;
            res_zero <= bus.alu_zero;
         end
         if (rsp_hs) last <= owner;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.rsp0_valid = rsp0_valid;
   assign bus.rsp1_valid = rsp1_valid;
   assign bus.rsp0_c     = res_c;
   assign bus.rsp1_c     = res_c;
   assign bus.rsp0_zero  = res_zero;
   assign bus.rsp1_zero  = res_zero;
   assign bus.alu_a      = op_a;
   assign bus.alu_b      = op_b;
   assign bus.alu_op     = op_code;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;

   localparam logic [1:0] ADDU = 2'd0;
   localparam logic [1:0] SUBU = 2'd1;
   localparam logic [1:0] ANDO = 2'd2;
   localparam logic [1:0] ORO  = 2'd3;

   typedef struct {
      bit          id;
      logic [31:0] c;
      logic        z;
   } rsp_t;

   logic clk;
   logic rst_n;

   alu_arbiter_if #(.WIDTH(32), .OPW(2)) bus ();

   alu_arbiter #(.WIDTH(32), .OPW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   rsp_mode = 0;

   rsp_t q0[$];
   rsp_t q1[$];
   rsp_t hist[$];
   bit   acc_order[$];
   int   acc_cyc[$];

   // model state: cycles since acceptance (0 = free), who owns it, who was served last
   int          m_age   = 0;
   bit          m_owner = 1'b0;
   bit          m_last  = 1'b1;
   logic [31:0] m_a     = '0;
   logic [31:0] m_b     = '0;
   logic [1:0]  m_op    = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      case (op)
         ADDU:    return a + b;
         SUBU:    return a - b;
         ANDO:    return a & b;
         default: return a | b;
      endcase
   endfunction

   // the shared single-cycle ALU
   always_comb begin
      bus.alu_c    = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
      bus.alu_zero = (bus.alu_a == bus.alu_b);
   end

   task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // idle requesters scramble their payload every cycle to expose any ALU input leakage
   always @(posedge clk) begin
      #2;
      if (!bus.req0_valid) begin
         bus.req0_a  = $urandom;
         bus.req0_b  = $urandom;
         bus.req0_op = 2'($urandom_range(0, 3));
      end
      if (!bus.req1_valid) begin
         bus.req1_a  = $urandom;
         bus.req1_b  = $urandom;
         bus.req1_op = 2'($urandom_range(0, 3));
      end
   end

   // response consumers: always ready, random, or left to the directed sequence
   always @(posedge clk) begin
      #1;
      if (rsp_mode == 0) begin
         bus.rsp0_ready = 1'b1;
         bus.rsp1_ready = 1'b1;
      end else if (rsp_mode == 1) begin
         bus.rsp0_ready = ($urandom_range(0, 2) != 0);
         bus.rsp1_ready = ($urandom_range(0, 2) != 0);
      end
   end

   // monitor: checks every cycle against the transaction model and retires responses from the scoreboard
   always @(negedge clk) begin
      bit   v0, v1, e_r0, e_r1, hs, have;
      rsp_t e;
      if (!rst_n) begin
         m_age   = 0;
         m_owner = 1'b0;
         m_last  = 1'b1;
         m_a     = '0;
         m_b     = '0;
         m_op    = '0;
      end else begin
         cyc++;
         v0   = bus.req0_valid;
         v1   = bus.req1_valid;
         e_r0 = (m_age == 0) && v0 && (!v1 || m_last);
         e_r1 = (m_age == 0) && v1 && (!v0 || !m_last);
         chk1("req0_ready", bus.req0_ready, e_r0);
         chk1("req1_ready", bus.req1_ready, e_r1);
         chk1("busy", bus.busy, m_age != 0);
         chk1("rsp0_valid", bus.rsp0_valid, (m_age >= 2) && !m_owner);
         chk1("rsp1_valid", bus.rsp1_valid, (m_age >= 2) && m_owner);
         chkw("alu_a", bus.alu_a, m_a);
         chkw("alu_b", bus.alu_b, m_b);
         chkw("alu_op", 32'(bus.alu_op), 32'(m_op));
         if (m_age >= 2) begin
            have = m_owner ? (q1.size() != 0) : (q0.size() != 0);
            hs   = m_owner ? bus.rsp1_ready : bus.rsp0_ready;
            n_chk++;
            if (!have) begin
               n_fail++;
               $display("FAIL rsp_expected: got response for requester %0d, expected none queued", m_owner);
            end else begin
               e = m_owner ? q1[0] : q0[0];
               chkw("rsp0_c", bus.rsp0_c, e.c);
               chkw("rsp1_c", bus.rsp1_c, e.c);
               chk1("rsp0_zero", bus.rsp0_zero, e.z);
               chk1("rsp1_zero", bus.rsp1_zero, e.z);
            end
            if (hs) begin
               if (have) begin
                  if (m_owner) void'(q1.pop_front());
                  else         void'(q0.pop_front());
               end
               hist.push_back('{m_owner, m_owner ? bus.rsp1_c : bus.rsp0_c,
                                m_owner ? bus.rsp1_zero : bus.rsp0_zero});
               m_last = m_owner;
               m_age  = 0;
            end else begin
               m_age++;
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else if (e_r0 || e_r1) begin
            m_owner = e_r1;
            m_a     = e_r1 ? bus.req1_a  : bus.req0_a;
            m_b     = e_r1 ? bus.req1_b  : bus.req0_b;
            m_op    = e_r1 ? bus.req1_op : bus.req0_op;
            acc_order.push_back(e_r1);
            acc_cyc.push_back(cyc);
            m_age   = 1;
         end
      end
   end

   // present one operation, queue its expected response, hold it until the accepting edge
   task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, output bit ok, output int waits);
      rsp_t e;
      @(posedge clk);
      #1;
      e.id = id;
      e.c  = alu_ref(a, b, op);
      e.z  = (a == b);
      if (id) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
         q1.push_back(e);
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
         q0.push_back(e);
      end
      ok    = 1'b0;
      waits = 0;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge clk);
         if (id ? bus.req1_ready : bus.req0_ready) ok = 1'b1;
         else waits++;
         @(posedge clk);
      end
      #1;
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
      chk1("issue_accepted", ok, 1'b1);
   endtask

   // single operation with explicit latency and value expectations
   task automatic directed(input bit id, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [31:0] ec, input logic ez);
      bit ok;
      int waits;
      issue(id, a, b, op, ok, waits);
      chkw("dir_ready_same_cycle", 32'(waits), 32'd0);
      chk1("dir_no_valid_in_exec", id ? bus.rsp1_valid : bus.rsp0_valid, 1'b0);
      @(posedge clk);
      #1;
      chk1("dir_valid_after_capture", id ? bus.rsp1_valid : bus.rsp0_valid, 1'b1);
      chkw("dir_c", id ? bus.rsp1_c : bus.rsp0_c, ec);
      chk1("dir_zero", id ? bus.rsp1_zero : bus.rsp0_zero, ez);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(posedge clk);
         #1;
         done = (q0.size() == 0) && (q1.size() == 0) && !bus.busy;
      end
      chk1("drain", done, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1({tag, "_req0_ready"}, bus.req0_ready, 1'b0);
      chk1({tag, "_req1_ready"}, bus.req1_ready, 1'b0);
      chk1({tag, "_rsp0_valid"}, bus.rsp0_valid, 1'b0);
      chk1({tag, "_rsp1_valid"}, bus.rsp1_valid, 1'b0);
      chk1({tag, "_busy"}, bus.busy, 1'b0);
      chkw({tag, "_alu_a"}, bus.alu_a, 32'd0);
      chkw({tag, "_alu_b"}, bus.alu_b, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok, ok2;
      int          waits, waits2;
      logic [31:0] held;
      logic [31:0] ra, rb;

      rst_n = 1'b0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;

      // reset while an operation sits in EXEC: it must vanish without a response
      issue(1'b0, 32'd9, 32'd4, ADDU, ok, waits);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midexec");
      q0.delete();
      q1.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      directed(1'b1, 32'd5, 32'd3, SUBU, 32'd2, 1'b0);
      drain();

      // tie after reset: requester 0 first, then strict alternation
      acc_order.delete();
      hist.delete();
      fork
         begin
            issue(1'b0, 32'd1, 32'd1, ADDU, ok, waits);
            issue(1'b0, 32'd1, 32'd1, ADDU, ok, waits);
         end
         begin
            issue(1'b1, 32'd7, 32'd7, ORO, ok2, waits2);
            issue(1'b1, 32'd7, 32'd7, ORO, ok2, waits2);
         end
      join
      drain();
      chkw("tie_grants", 32'(acc_order.size()), 32'd4);
      for (int k = 0; k < acc_order.size() && k < 4; k++)
         chkw("tie_grant_order", 32'(acc_order[k]), 32'(k % 2));
      chkw("tie_rsp_count", 32'(hist.size()), 32'd4);
      if (hist.size() >= 2) begin
         chkw("tie_first_c", hist[0].c, 32'd2);
         chk1("tie_first_zero", hist[0].z, 1'b1);
         chkw("tie_second_c", hist[1].c, 32'd7);
         chk1("tie_second_zero", hist[1].z, 1'b1);
      end

      // response stall on requester 0 while requester 1 waits
      rsp_mode = 2;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b1;
      fork
         begin
            issue(1'b0, 32'h1234, 32'h1234, ANDO, ok, waits);
            @(posedge clk);
            #1;
            held = bus.rsp0_c;
            chkw("stall_c_value", held, 32'h1234);
            repeat (5) begin
               chk1("stall_valid_held", bus.rsp0_valid, 1'b1);
               chkw("stall_c_held", bus.rsp0_c, held);
               chk1("stall_req1_blocked", bus.req1_ready, 1'b0);
               @(posedge clk);
               #1;
            end
            bus.rsp0_ready = 1'b1;
         end
         begin
            issue(1'b1, 32'd100, 32'd58, SUBU, ok2, waits2);
         end
      join
      drain();
      rsp_mode = 0;

      // back-to-back stream from requester 0 with an always-ready consumer
      acc_cyc.delete();
      hist.delete();
      issue(1'b0, 32'hFFFF_FFFF, 32'd1, ADDU, ok, waits);
      issue(1'b0, 32'd10, 32'd10, SUBU, ok, waits);
      issue(1'b0, 32'hF0F0_0000, 32'h0F0F_0000, ORO, ok, waits);
      issue(1'b0, 32'h8000_0000, 32'h8000_0000, ADDU, ok, waits);
      drain();
      chkw("b2b_accepts", 32'(acc_cyc.size()), 32'd4);
      for (int k = 1; k < acc_cyc.size(); k++)
         chkw("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
      if (hist.size() >= 1) begin
         chkw("b2b_wrap_c", hist[0].c, 32'd0);
         chk1("b2b_wrap_zero", hist[0].z, 1'b0);
      end

      // randomized contention with a randomly stalling consumer
      rsp_mode = 1;
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               bit o; int w;
               repeat ($urandom_range(0, 2)) @(posedge clk);
               ra = $urandom;
               rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
               issue(1'b0, ra, rb, 2'($urandom_range(0, 3)), o, w);
            end
         end
         begin
            for (int k = 0; k < 25; k++) begin
               bit o; int w;
               logic [31:0] xa, xb;
               repeat ($urandom_range(0, 2)) @(posedge clk);
               xa = $urandom;
               xb = ($urandom_range(0, 3) == 0) ? xa : $urandom;
               issue(1'b1, xa, xb, 2'($urandom_range(0, 3)), o, w);
            end
         end
      join
      rsp_mode = 0;
      drain();
      chkw("final_q0_empty", 32'(q0.size()), 32'd0);
      chkw("final_q1_empty", 32'(q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
